// File: rtl/isp_bnr_pkg.sv
// Shared types and constants for the Bayer noise-reduction stage.
// Weight-set fields are WB_MAX wide; narrower weights are zero-extended.
package isp_bnr_pkg;
    localparam int LATENCY = 5;
    localparam int WB_MAX  = 8;

    typedef enum logic {CLS_RB = 1'b0, CLS_G = 1'b1} cls_e;

    typedef struct packed {
        logic [WB_MAX-1:0] wc;
        logic [WB_MAX-1:0] w1;
        logic [WB_MAX-1:0] w2;
    } wset_t;

    function automatic int sumw(input int bits, input int wbits);
        return bits + wbits + 4;
    endfunction
endpackage

// File: rtl/isp_bnr_mac.sv
// Weighted 9-tap sum with rounding right-shift and saturation.
// Latency: 3 pclk (ring sums, weighted sum, round/shift/saturate); no backpressure.
module isp_bnr_mac
    import isp_bnr_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WBITS = 4
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic [BITS-1:0]      c,
    input  logic [3:0][BITS-1:0] r1,
    input  logic [3:0][BITS-1:0] r2,
    input  wset_t                wts,
    input  logic [3:0]           shift,
    output logic [BITS-1:0]      res
);
    localparam int SUMW = sumw(BITS, WBITS);
    localparam int RNDW = SUMW + 1;
    localparam int RSW  = BITS + 2;

    logic [BITS-1:0] c_a_q, c_a_d;
    logic [RSW-1:0]  s1_a_q, s1_a_d, s2_a_q, s2_a_d;
    wset_t           w_a_q, w_a_d;
    logic [3:0]      sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [SUMW-1:0] sum_b_q, sum_b_d;
    logic [BITS-1:0] res_c_q, res_c_d;
    logic [RNDW-1:0] rnd, shd;

    always_comb begin
        c_a_d   = c;
        w_a_d   = wts;
        sh_a_d  = shift;
        s1_a_d  = RSW'(r1[0]) + RSW'(r1[1]) + RSW'(r1[2]) + RSW'(r1[3]);
        s2_a_d  = RSW'(r2[0]) + RSW'(r2[1]) + RSW'(r2[2]) + RSW'(r2[3]);
        sum_b_d = SUMW'(w_a_q.wc) * SUMW'(c_a_q)
                + SUMW'(w_a_q.w1) * SUMW'(s1_a_q)
                + SUMW'(w_a_q.w2) * SUMW'(s2_a_q);
        sh_b_d  = sh_a_q;
        // One extra bit keeps the rounding add from wrapping before the shift.
        rnd = RNDW'(sum_b_q);
        if (sh_b_q != 4'd0) rnd = rnd + (RNDW'(1) << (sh_b_q - 4'd1));
        shd = rnd >> sh_b_q;
        res_c_d = (shd > RNDW'({BITS{1'b1}})) ? {BITS{1'b1}} : shd[BITS-1:0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            c_a_q   <= '0;
            s1_a_q  <= '0;
            s2_a_q  <= '0;
            w_a_q   <= '0;
            sh_a_q  <= '0;
            sum_b_q <= '0;
            sh_b_q  <= '0;
            res_c_q <= '0;
        end else begin
            c_a_q   <= c_a_d;
            s1_a_q  <= s1_a_d;
            s2_a_q  <= s2_a_d;
            w_a_q   <= w_a_d;
            sh_a_q  <= sh_a_d;
            sum_b_q <= sum_b_d;
            sh_b_q  <= sh_b_d;
            res_c_q <= res_c_d;
        end
    end

    assign res = res_c_q;
endmodule

// File: rtl/shift_register.sv
// Enabled shift register used as a line delay: q is the sample pushed DEPTH enables ago.
// Latency: DEPTH enabled cycles; no backpressure, shifts whenever en is high.
module shift_register #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) mem_d = {mem_q[DEPTH-2:0], d};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign q = mem_q[DEPTH-1];
endmodule

// File: rtl/isp_bnr_prog.sv
// Bayer 5x5 same-colour noise reduction with frame-synchronous programmable weights.
// Latency: 5 pclk, fixed in both modes; no backpressure (href/vsync streaming).
module isp_bnr_prog
    import isp_bnr_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 3,
    parameter int WBITS  = 4
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic [WBITS-1:0] cfg_wc_rb,
    input  logic [WBITS-1:0] cfg_w1_rb,
    input  logic [WBITS-1:0] cfg_w2_rb,
    input  logic [WBITS-1:0] cfg_wc_g,
    input  logic [WBITS-1:0] cfg_w1_g,
    input  logic [WBITS-1:0] cfg_w2_g,
    input  logic [3:0]       cfg_shift,
    input  logic             in_href,
    input  logic             in_vsync,
    input  logic [BITS-1:0]  in_raw,
    output logic             out_href,
    output logic             out_vsync,
    output logic [BITS-1:0]  out_raw
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int CD = LATENCY - 2;
    localparam logic [1:0] BPH = 2'(BAYER);

    logic                      href_prev_q, href_prev_d, vs_prev_q, vs_prev_d;
    logic [CW-1:0]             col_q, col_d, p1_col_q, p1_col_d;
    logic [RW-1:0]             row_q, row_d, p1_row_q, p1_row_d;
    logic                      act_en_q, act_en_d;
    wset_t                     act_rb_q, act_rb_d, act_g_q, act_g_d;
    logic [3:0]                act_sh_q, act_sh_d;
    logic [4:0][4:0][BITS-1:0] win_q, win_d;
    logic                      p1_href_q, p1_href_d, p1_vs_q, p1_vs_d;
    logic [CD-1:0][2:0]        ctl_q, ctl_d;
    logic                      out_href_q, out_href_d, out_vs_q, out_vs_d;
    logic [BITS-1:0]           out_raw_q, out_raw_d;

    logic [3:0][BITS-1:0] lb_in, lb_out, ax, cn, dg, ring1, ring2;
    logic [4:0][BITS-1:0] col_v;
    logic [BITS-1:0]      ctr, mac_res;
    logic [1:0]           ph;
    cls_e                 cls;
    logic                 t1, t2, l1, l2, valid1;
    wset_t                wts;
    logic [3:0]           sh;
    logic                 unused_win;

    assign lb_in      = {lb_out[2:0], in_raw};
    assign col_v      = {in_raw, lb_out[0], lb_out[1], lb_out[2], lb_out[3]};
    assign unused_win = ^{win_q[1][0], win_q[3][0]};

    for (genvar i = 0; i < 4; i++) begin : g_lb
        shift_register #(.W(BITS), .DEPTH(WIDTH)) u_lb (
            .pclk (pclk),
            .rst_n(rst_n),
            .en   (in_href),
            .d    (lb_in[i]),
            .q    (lb_out[i])
        );
    end

    always_comb begin
        href_prev_d = in_href;
        vs_prev_d   = in_vsync;
        col_d = '0;
        if (in_href && !in_vsync)
            col_d = (col_q == CW'(WIDTH - 1)) ? col_q : col_q + CW'(1);
        row_d = row_q;
        if (in_vsync)
            row_d = '0;
        else if (href_prev_q && !in_href && row_q != RW'(HEIGHT - 1))
            row_d = row_q + RW'(1);

        act_en_d = act_en_q;
        act_rb_d = act_rb_q;
        act_g_d  = act_g_q;
        act_sh_d = act_sh_q;
        if (in_vsync && !vs_prev_q) begin
            act_en_d = cfg_en;
            act_rb_d = '{wc: WB_MAX'(cfg_wc_rb), w1: WB_MAX'(cfg_w1_rb), w2: WB_MAX'(cfg_w2_rb)};
            act_g_d  = '{wc: WB_MAX'(cfg_wc_g),  w1: WB_MAX'(cfg_w1_g),  w2: WB_MAX'(cfg_w2_g)};
            act_sh_d = cfg_shift;
        end

        // Row 4 / column 4 of the window hold the newest input; centre is (2,2).
        win_d = win_q;
        if (in_href)
            for (int i = 0; i < 5; i++) win_d[i] = {col_v[i], win_q[i][4:1]};
        p1_href_d = in_href;
        p1_vs_d   = in_vsync;
        p1_row_d  = row_q;
        p1_col_d  = col_q;

        // Taps above or left of the frame fall back to the centre value.
        ctr = win_q[2][2];
        t2  = p1_row_q < RW'(4);
        t1  = p1_row_q < RW'(3);
        l2  = p1_col_q < CW'(4);
        l1  = p1_col_q < CW'(3);
        ax[0] = t2 ? ctr : win_q[0][2];
        ax[1] = win_q[4][2];
        ax[2] = l2 ? ctr : win_q[2][0];
        ax[3] = win_q[2][4];
        cn[0] = (t2 || l2) ? ctr : win_q[0][0];
        cn[1] = t2 ? ctr : win_q[0][4];
        cn[2] = l2 ? ctr : win_q[4][0];
        cn[3] = win_q[4][4];
        dg[0] = (t1 || l1) ? ctr : win_q[1][1];
        dg[1] = t1 ? ctr : win_q[1][3];
        dg[2] = l1 ? ctr : win_q[3][1];
        dg[3] = win_q[3][3];

        ph    = BPH ^ {p1_row_q[0], p1_col_q[0]};
        cls   = (ph == 2'd0 || ph == 2'd3) ? CLS_RB : CLS_G;
        ring1 = (cls == CLS_RB) ? ax : dg;
        ring2 = (cls == CLS_RB) ? cn : ax;
        // Bypass reuses the MAC as a unity pass so latency is mode-independent.
        wts = '0;
        wts.wc = WB_MAX'(1);
        sh = 4'd0;
        if (act_en_q) begin
            wts = (cls == CLS_RB) ? act_rb_q : act_g_q;
            sh  = act_sh_q;
        end
        valid1 = (p1_row_q >= RW'(2)) && (p1_col_q >= CW'(2));

        ctl_d      = {ctl_q[CD-2:0], {p1_href_q, p1_vs_q, valid1}};
        out_href_d = ctl_q[CD-1][2];
        out_vs_d   = ctl_q[CD-1][1];
        out_raw_d  = (ctl_q[CD-1][2] && ctl_q[CD-1][0]) ? mac_res : '0;
    end

    isp_bnr_mac #(.BITS(BITS), .WBITS(WBITS)) u_mac (
        .pclk (pclk),
        .rst_n(rst_n),
        .c    (ctr),
        .r1   (ring1),
        .r2   (ring2),
        .wts  (wts),
        .shift(sh),
        .res  (mac_res)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev_q <= 1'b0;
            vs_prev_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            act_en_q    <= 1'b0;
            act_rb_q    <= '0;
            act_g_q     <= '0;
            act_sh_q    <= '0;
            win_q       <= '0;
            p1_href_q   <= 1'b0;
            p1_vs_q     <= 1'b0;
            p1_row_q    <= '0;
            p1_col_q    <= '0;
            ctl_q       <= '0;
            out_href_q  <= 1'b0;
            out_vs_q    <= 1'b0;
            out_raw_q   <= '0;
        end else begin
            href_prev_q <= href_prev_d;
            vs_prev_q   <= vs_prev_d;
            col_q       <= col_d;
            row_q       <= row_d;
            act_en_q    <= act_en_d;
            act_rb_q    <= act_rb_d;
            act_g_q     <= act_g_d;
            act_sh_q    <= act_sh_d;
            win_q       <= win_d;
            p1_href_q   <= p1_href_d;
            p1_vs_q     <= p1_vs_d;
            p1_row_q    <= p1_row_d;
            p1_col_q    <= p1_col_d;
            ctl_q       <= ctl_d;
            out_href_q  <= out_href_d;
            out_vs_q    <= out_vs_d;
            out_raw_q   <= out_raw_d;
        end
    end

    assign out_href  = out_href_q;
    assign out_vsync = out_vs_q;
    assign out_raw   = out_raw_q;
endmodule

// File: tb/tb_isp_bnr_prog.sv
// Directed frames against a reference image model; expected outputs queued at drive time.
module tb_isp_bnr_prog;
    localparam int BITS = 8, WIDTH = 12, HEIGHT = 8, BAYER = 0, WBITS = 4, LAT = 5;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic [3:0] cfg_wc_rb = '0, cfg_w1_rb = '0, cfg_w2_rb = '0;
    logic [3:0] cfg_wc_g = '0, cfg_w1_g = '0, cfg_w2_g = '0;
    logic [3:0] cfg_shift = '0;
    logic       in_href = 1'b0, in_vsync = 1'b0;
    logic [7:0] in_raw = '0;
    logic       out_href, out_vsync;
    logic [7:0] out_raw;

    always #5 pclk = ~pclk;

    isp_bnr_prog #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(BAYER), .WBITS(WBITS)) dut (
        .pclk(pclk), .rst_n(rst_n), .cfg_en(cfg_en),
        .cfg_wc_rb(cfg_wc_rb), .cfg_w1_rb(cfg_w1_rb), .cfg_w2_rb(cfg_w2_rb),
        .cfg_wc_g(cfg_wc_g), .cfg_w1_g(cfg_w1_g), .cfg_w2_g(cfg_w2_g),
        .cfg_shift(cfg_shift), .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw)
    );

    typedef struct {
        int   due;
        int   fid;
        int   r;
        int   k;
        logic href;
        logic vs;
        int   raw;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ncmp = 0, nerr = 0;
    int   fid = 0;
    int   img[HEIGHT][WIDTH];
    int   m_en = 0, m_sh = 0, m_wc_rb = 0, m_w1_rb = 0, m_w2_rb = 0, m_wc_g = 0, m_w1_g = 0, m_w2_g = 0;
    bit   tb_prev_vs = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("f%0d(%0d,%0d) out_href", e.fid, e.r, e.k), int'(out_href), int'(e.href));
            chk($sformatf("f%0d(%0d,%0d) out_vsync", e.fid, e.r, e.k), int'(out_vsync), int'(e.vs));
            chk($sformatf("f%0d(%0d,%0d) out_raw", e.fid, e.r, e.k), int'(out_raw), e.raw);
        end
    end

    function automatic int px(input int rr, input int cc, input int c);
        if (rr < 0 || cc < 0) return c;
        return img[rr][cc];
    endfunction

    function automatic int model(input int r, input int k);
        int cr, cc, c, ax, cn, dg, s1, s2, wc, w1, w2, sum, ph;
        bit rb;
        if (r < 2 || k < 2) return 0;
        cr = r - 2;
        cc = k - 2;
        c  = img[cr][cc];
        if (m_en == 0) return c;
        ph = BAYER ^ ((cr % 2) * 2 + (cc % 2));
        rb = (ph == 0 || ph == 3);
        ax = px(cr-2, cc, c) + px(cr+2, cc, c) + px(cr, cc-2, c) + px(cr, cc+2, c);
        cn = px(cr-2, cc-2, c) + px(cr-2, cc+2, c) + px(cr+2, cc-2, c) + px(cr+2, cc+2, c);
        dg = px(cr-1, cc-1, c) + px(cr-1, cc+1, c) + px(cr+1, cc-1, c) + px(cr+1, cc+1, c);
        s1 = rb ? ax : dg;
        s2 = rb ? cn : ax;
        wc = rb ? m_wc_rb : m_wc_g;
        w1 = rb ? m_w1_rb : m_w1_g;
        w2 = rb ? m_w2_rb : m_w2_g;
        sum = wc * c + w1 * s1 + w2 * s2;
        if (m_sh != 0) sum = sum + (1 << (m_sh - 1));
        sum = sum >> m_sh;
        return (sum > 255) ? 255 : sum;
    endfunction

    task automatic step(input logic h, input logic v, input int raw, input int r, input int k);
        exp_t e;
        if (v && !tb_prev_vs) begin
            m_en = cfg_en; m_sh = cfg_shift;
            m_wc_rb = cfg_wc_rb; m_w1_rb = cfg_w1_rb; m_w2_rb = cfg_w2_rb;
            m_wc_g = cfg_wc_g; m_w1_g = cfg_w1_g; m_w2_g = cfg_w2_g;
        end
        tb_prev_vs = v;
        in_href  = h;
        in_vsync = v;
        in_raw   = 8'(raw);
        e.due  = cyc + LAT;
        e.fid  = fid;
        e.r    = r;
        e.k    = k;
        e.href = h;
        e.vs   = v;
        e.raw  = h ? model(r, k) : 0;
        sb.push_back(e);
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input int en, input int a, input int b, input int c,
                           input int d, input int e, input int f, input int s);
        cfg_en = 1'(en);
        cfg_wc_rb = 4'(a); cfg_w1_rb = 4'(b); cfg_w2_rb = 4'(c);
        cfg_wc_g = 4'(d); cfg_w1_g = 4'(e); cfg_w2_g = 4'(f);
        cfg_shift = 4'(s);
    endtask

    task automatic run_frame(input int id, input bit do_vs, input int chg_row, input int chg_shift);
        fid = id;
        if (do_vs) begin
            repeat (2) step(0, 0, 0, -1, -1);
            repeat (2) step(0, 1, 0, -1, -1);
            repeat (3) step(0, 0, 0, -1, -1);
        end
        for (int r = 0; r < HEIGHT; r++) begin
            if (r == chg_row) cfg_shift = 4'(chg_shift);
            for (int k = 0; k < WIDTH; k++) step(1, 0, img[r][k], r, k);
            repeat (4) step(0, 0, 0, r, -1);
        end
    endtask

    task automatic fill(input int mode, input int a, input int b);
        for (int r = 0; r < HEIGHT; r++)
            for (int k = 0; k < WIDTH; k++)
                case (mode)
                    0: img[r][k] = a;
                    1: img[r][k] = (k + 16 * r) % 256;
                    2: img[r][k] = (((r % 2) == (k % 2)) ? a : b);
                    default: img[r][k] = int'($urandom_range(255, 0));
                endcase
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        chk("reset out_href", int'(out_href), 0);
        chk("reset out_vsync", int'(out_vsync), 0);
        chk("reset out_raw", int'(out_raw), 0);
        rst_n = 1'b1;
        @(posedge pclk);
        #1;

        fill(0, 100, 0);  set_cfg(1, 4, 2, 1, 4, 2, 1, 4);       run_frame(1, 1, -1, 0);
        fill(1, 0, 0);    set_cfg(0, 4, 2, 1, 4, 2, 1, 4);       run_frame(2, 1, -1, 0);
        fill(0, 255, 0);  set_cfg(1, 15, 15, 15, 15, 15, 15, 0); run_frame(3, 1, -1, 0);
        fill(0, 100, 0);  set_cfg(1, 4, 2, 1, 4, 2, 1, 4);       run_frame(4, 1, 3, 5);
        run_frame(5, 1, -1, 0);
        fill(2, 200, 40); set_cfg(1, 8, 2, 0, 8, 2, 0, 4);       run_frame(6, 1, -1, 0);
        fill(3, 0, 0);    set_cfg(1, 3, 2, 1, 5, 1, 2, 3);       run_frame(7, 1, -1, 0);

        // Reset in the middle of a line, after valid outputs have started flowing.
        for (int k = 0; k < 5; k++) begin
            in_href = 1'b1; in_vsync = 1'b0; in_raw = 8'(img[0][k]);
            @(posedge pclk);
            #1;
        end
        sb.delete();
        in_href = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset out_href", int'(out_href), 0);
        chk("midreset out_vsync", int'(out_vsync), 0);
        chk("midreset out_raw", int'(out_raw), 0);
        repeat (3) begin
            @(posedge pclk);
            #1;
            chk("held reset out_href", int'(out_href), 0);
            chk("held reset out_raw", int'(out_raw), 0);
        end
        rst_n = 1'b1;
        m_en = 0; m_sh = 0; m_wc_rb = 0; m_w1_rb = 0; m_w2_rb = 0; m_wc_g = 0; m_w1_g = 0; m_w2_g = 0;
        tb_prev_vs = 1'b0;
        @(posedge pclk);
        #1;

        fill(3, 0, 0);    set_cfg(1, 4, 2, 1, 4, 2, 1, 4);       run_frame(8, 0, -1, 0);
        fill(1, 0, 0);    set_cfg(0, 4, 2, 1, 4, 2, 1, 4);       run_frame(9, 1, -1, 0);

        repeat (LAT + 2) @(posedge pclk);
        #1;
        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/isp_bnr_prog.md
Name: isp_bnr_prog

Overview:
- Programmable Bayer-domain noise-reduction filter: a 5x5 same-colour weighted average with run-time weights per colour class (R/B vs Gr/Gb) and a programmable normalising shift.
- Configuration is double-buffered and takes effect only at frame start. Missing top/left neighbours are substituted with the centre pixel, and the output saturates.
- Sits in the raw ISP chain after DPC and before demosaic. Its streaming interface (href/vsync/raw) is drop-in with the other isp_* stages.

Parameters:
BITS, 8, raw pixel width
WIDTH, 1280, active pixels per line (line-buffer depth)
HEIGHT, 960, active lines per frame (row-counter range)
BAYER, 3, CFA phase of pixel (0,0): 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
WBITS, 4, width of each unsigned weight

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
cfg_en  in  1  1 = filter, 0 = bypass (centre pixel passed through)
cfg_wc_rb, cfg_w1_rb, cfg_w2_rb  in  WBITS each  R/B centre, ring-1, ring-2 weights
cfg_wc_g, cfg_w1_g, cfg_w2_g  in  WBITS each  G centre, ring-1, ring-2 weights
cfg_shift  in  4  right-shift applied to the weighted sum
in_href  in  1  line valid
in_vsync  in  1  frame sync, active high
in_raw  in  BITS  input pixel
out_href  out  1  in_href delayed LATENCY
out_vsync  out  1  in_vsync delayed LATENCY
out_raw  out  BITS  filtered pixel; 0 when out_href low

Behaviour:
- Reset and clocking: clock pclk, reset rst_n asynchronous active-low. All registers clear on reset, including the active config (cfg_en=0, weights 0, shift 0). Outputs reset to 0.
- Config shadowing:
  - cfg_* are sampled into the active set on the cycle the rising edge of in_vsync is detected (in_vsync=1, previous=0).
  - Changes at any other time have no effect until the next rising edge.
  - A reset mid-frame returns the block to bypass until the next vsync rise.
- Position tracking:
  - col counts href-high cycles from 0 and clears while href is low.
  - row increments on href falling edge and clears while in_vsync is high.
  - Both saturate at WIDTH-1 and HEIGHT-1.
- Window: a 4-line buffer plus 5x5 register window. The centre for the output at input position (r,k) is input pixel (r-2,k-2).
- Colour phase: taken from BAYER xor {r[0],k[0]}. Phases 0 and 3 are R/B class; phases 1 and 2 are G class.
- Rings:
  - R/B class: ring1 = 4 axial taps at distance 2; ring2 = 4 corner taps at (±2,±2).
  - G class: ring1 = 4 diagonal taps at (±1,±1); ring2 = 4 axial taps at distance 2.
- Border substitution:
  - Any tap whose row is < 0 or column is < 0 (relative to the frame) is replaced by the centre value.
  - If the centre itself is outside the frame (r<2 or k<2), out_raw = 0 while out_href = 1.
- Arithmetic:
  - sum = wc*C + w1*sum(ring1) + w2*sum(ring2), computed unsigned at width BITS+WBITS+4.
  - result = (sum + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >> cfg_shift, saturated to 2^BITS-1.
- Bypass: when cfg_en=0, out_raw is the centre pixel with the same latency. Border zeroing still applies.
- Latency: LATENCY = 5 cycles (window, partial sums, final sum, round/shift/saturate, output register). It is fixed and independent of mode.
- Frame handling: vsync asserted mid-line aborts the line. Counters clear and line-buffer contents are don't-care for the first 2 rows, which are covered by border zeroing.

Decomposition:
- Package isp_bnr_pkg holds:
  - LATENCY;
  - the class encoding (CLS_RB, CLS_G);
  - the SUMW = BITS+WBITS+4 width function;
  - the weight-set struct {wc, w1, w2}.
- Sub-module isp_bnr_mac takes the 9 taps, weight set and shift, and produces the saturated result over 3 pipeline stages.
- The line buffer reuses the team's shift_register.

Test Plan:
1. Flat frame: all pixels 100, weights (4,2,1) both classes, shift 4 → interior out_raw = 100 (sum 1600>>4); first 2 rows and cols = 0.
2. Bypass: cfg_en=0, ramp in_raw = k mod 256 → out_raw at (r,k) = (k-2) for k≥2, r≥2; out_href equals in_href delayed 5.
3. Saturation: all pixels 255, weights (15,15,15), shift 0 → out_raw = 255.
4. Shadowing: change cfg_shift 4→5 mid-frame → current frame unchanged (100). Next frame, after the vsync rise, gives 50.
5. Class separation: R/B pixels 200, G pixels 40, BAYER=0, weights (8,2,0) shift 4 → interior R/B out 200, G out 40 (no cross-colour leakage).
6. Reset mid-line: assert rst_n low for 3 cycles → all outputs 0 immediately. Block resumes in bypass after the next vsync rise with cfg_en=0.
